// File: rtl/egk_stream_binarizer.sv
// k-th order Exp-Golomb binarizer: one bin per clock, valid/ready on both sides.
// Optional EGK_OVERFLOW_CHECK_EN: truncate at MAX_BITS bins and flag overflow.
module egk_stream_binarizer #(
  parameter int SYMBOL_BITS = 8,
  parameter int MAX_BITS    = 32,
  parameter int LEN_BITS    = $clog2(MAX_BITS+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             k_param,
  input  logic [1:0]             mode,
  input  logic [SYMBOL_BITS-1:0] symbol_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAX_BITS-1:0]    code,
  output logic [LEN_BITS-1:0]    code_len,
  output logic                   overflow
);
  localparam int VAL_BITS = SYMBOL_BITS + 1;
  localparam int KB       = $clog2(SYMBOL_BITS + 1);
  localparam logic signed [VAL_BITS:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_SUFFIX, S_SIGN, S_OUT} state_t;

  typedef struct packed {
    logic [KB-1:0]       k;
    logic [VAL_BITS-1:0] v;
    logic                sign_en;
    logic                neg;
  } sym_t;

  state_t                state, state_nxt;
  sym_t                  sym_q, sym_in;
  logic [KB-1:0]         cnt_q;
  logic [VAL_BITS-1:0]   pow_k, v_shr;
  logic signed [VAL_BITS:0] s_ext, s_dbl, m_val;
  logic                  accept, shift_req, ovf_hit, ge_pow, k_sat, bin;

  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign accept    = in_valid && in_ready;
  assign shift_req = (state == S_PREFIX) || (state == S_SUFFIX) || (state == S_SIGN);
  assign pow_k     = VAL_BITS'(1) << sym_q.k;
  assign v_shr     = sym_q.v >> cnt_q;
  assign ge_pow    = (sym_q.v >= pow_k);
  assign k_sat     = (sym_q.k == KB'(SYMBOL_BITS));

`ifdef EGK_OVERFLOW_CHECK_EN
  // A bin arriving with the register already full is dropped.
  assign ovf_hit = shift_req && (code_len == LEN_BITS'(MAX_BITS));
`else
  assign ovf_hit = 1'b0;
`endif

  // Symbol mapping evaluated on the input side, captured on accept.
  always_comb begin
    sym_in = '0;
    s_ext  = {{2{symbol_val[SYMBOL_BITS-1]}}, symbol_val};
    s_dbl  = s_ext <<< 1;
    m_val  = '0;
    case (mode)
      2'b01:   m_val = symbol_val[SYMBOL_BITS-1] ? -s_ext : s_ext;
      2'b10:   m_val = (!s_ext[VAL_BITS] && (s_ext != '0)) ? (s_dbl - ONE) : -s_dbl;
      default: m_val = {2'b00, symbol_val};
    endcase
    sym_in.v       = m_val[VAL_BITS-1:0];
    sym_in.k       = (int'(k_param) > SYMBOL_BITS) ? KB'(SYMBOL_BITS) : KB'(k_param);
    sym_in.sign_en = (mode == 2'b01) && (|symbol_val);
    sym_in.neg     = (mode == 2'b01) && symbol_val[SYMBOL_BITS-1];
  end

  always_comb begin
    state_nxt = state;
    bin       = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PREFIX;
      S_PREFIX: begin
        bin = ge_pow;
        if (!ge_pow) begin
          if (sym_q.k != '0)       state_nxt = S_SUFFIX;
          else if (sym_q.sign_en)  state_nxt = S_SIGN;
          else                     state_nxt = S_OUT;
        end
      end
      S_SUFFIX: begin
        bin = v_shr[0];
        if (cnt_q == '0) state_nxt = sym_q.sign_en ? S_SIGN : S_OUT;
      end
      S_SIGN: begin
        bin       = sym_q.neg;
        state_nxt = S_OUT;
      end
      S_OUT: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (ovf_hit) state_nxt = S_OUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q    <= '0;
      cnt_q    <= '0;
      code     <= '0;
      code_len <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      sym_q    <= sym_in;
      code     <= '0;
      code_len <= '0;
      overflow <= 1'b0;
    end else if (ovf_hit) begin
      overflow <= 1'b1;
    end else if (shift_req) begin
      code     <= {code[MAX_BITS-2:0], bin};
      code_len <= code_len + 1'b1;
      if (state == S_PREFIX) begin
        if (ge_pow) begin
          sym_q.v <= sym_q.v - pow_k;
          if (!k_sat) sym_q.k <= sym_q.k + 1'b1;
        end else begin
          cnt_q <= sym_q.k - 1'b1;
        end
      end
      if (state == S_SUFFIX) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_egk_stream_binarizer.sv
// Scoreboard bench for egk_stream_binarizer (SYMBOL_BITS=8, MAX_BITS=16).
module tb_egk_stream_binarizer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  k_param = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  symbol_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] code;
  logic [4:0]  code_len;
  logic        overflow;

  egk_stream_binarizer #(.SYMBOL_BITS(8), .MAX_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .k_param(k_param), .mode(mode), .symbol_val(symbol_val),
    .out_valid(out_valid), .out_ready(out_ready), .code(code),
    .code_len(code_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] code;
    logic [4:0]  len;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   edges = 0;
  bit   trk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; holds in_valid for exactly one accept edge.
  task automatic send(input logic [3:0] k, input logic [1:0] m, input logic [7:0] s,
                      input logic [15:0] c, input int len, input logic ov,
                      input int lat, input bit push);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    k_param = k; mode = m; symbol_val = s; in_valid = 1'b1;
    if (push) sb_q.push_back('{c, 5'(len), ov, lat});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || !in_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", sb_q.size(), 32'd0);
  endtask

  // Monitor: latency from accept edge to out_valid, then payload on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      trk = 1'b0;
    end else begin
      if (trk) begin
        if (out_valid) begin
          trk = 1'b0;
          if (sb_q.size() == 0) chk("latency_noexp", 32'd1, 32'd0);
          else                  chk("latency", edges, sb_q[0].lat);
        end else begin
          edges++;
        end
      end
      if (in_valid && in_ready) begin
        trk   = 1'b1;
        edges = 0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("code", {16'd0, code}, {16'd0, e.code});
          chk("code_len", {27'd0, code_len}, {27'd0, e.len});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_code", {16'd0, code}, 32'd0);
    chk("rst_len", {27'd0, code_len}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    //     k      mode   sym     code     len ovf lat
    send(4'd0,  2'b00, 8'd0,   16'h0000, 1,  0, 1,  1);
    send(4'd0,  2'b00, 8'd3,   16'h0018, 5,  0, 5,  1);
    send(4'd1,  2'b00, 8'd5,   16'h000B, 4,  0, 4,  1);
    send(4'd0,  2'b10, 8'hFE,  16'h0019, 5,  0, 5,  1);
    send(4'd0,  2'b01, 8'hFF,  16'h0009, 4,  0, 4,  1);
    send(4'd0,  2'b01, 8'h00,  16'h0000, 1,  0, 1,  1);
    send(4'd15, 2'b00, 8'd5,   16'h0005, 9,  0, 9,  1);
    send(4'd0,  2'b11, 8'd3,   16'h0018, 5,  0, 5,  1);
    send(4'd0,  2'b01, 8'h80,  16'hFE03, 16, 0, 16, 1);
    send(4'd0,  2'b10, 8'd3,   16'h001A, 5,  0, 5,  1);
    send(4'd8,  2'b10, 8'h80,  16'h0200, 10, 0, 10, 1);
    send(4'd2,  2'b01, 8'd5,   16'h0022, 6,  0, 6,  1);
`ifdef EGK_OVERFLOW_CHECK_EN
    send(4'd0,  2'b00, 8'd255, 16'hFF00, 16, 1, 17, 1);
`else
    send(4'd0,  2'b00, 8'd255, 16'hFE00, 17, 0, 17, 1);
`endif
    send(4'd0,  2'b00, 8'd0,   16'h0000, 1,  0, 1,  1);
    drain();

    // Backpressure then a back-to-back symbol.
    out_ready = 1'b0;
    send(4'd0, 2'b00, 8'd3, 16'h0018, 5, 0, 5, 1);
    for (int t = 0; t < 50 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("bp_reached_out", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_code", {16'd0, code}, 32'h18);
      chk("bp_len", {27'd0, code_len}, 32'd5);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    send(4'd1, 2'b00, 8'd5, 16'h000B, 4, 0, 4, 1);
    drain();

    // Reset in the middle of a prefix run.
    send(4'd0, 2'b00, 8'd200, 16'h0000, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_code", {16'd0, code}, 32'd0);
    chk("abort_len", {27'd0, code_len}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd0, 2'b00, 8'd200, 16'h7F49, 15, 0, 15, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/egk_stream_binarizer.md
# egk_stream_binarizer

Parametrised k-th order Exp-Golomb (EGk) binarizer with valid/ready handshakes on both sides and three value-mapping modes: unsigned, abs + sign bit, and zig-zag. It sits in the HEVC binarization path between syntax-element generation and the bypass-bin packer. It emits one code per symbol as a right-aligned bit vector plus its length, building one bin per clock.

## Interface
- SYMBOL_BITS, 8, width of `symbol_val`; internal value width VAL_BITS = SYMBOL_BITS+1
- MAX_BITS, 32, width of `code`; the maximum code length the block can represent
- LEN_BITS, $clog2(MAX_BITS+1), width of `code_len`

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  symbol available
- in_ready  out  1  block can accept a symbol
- k_param  in  4  EG order k; latched on accept; values above SYMBOL_BITS clamp to SYMBOL_BITS
- mode  in  2  00 unsigned, 01 abs+sign, 10 zig-zag, 11 reserved (treated as 00); latched on accept
- symbol_val  in  SYMBOL_BITS  two's complement input in modes 01/10, unsigned input in mode 00
- out_valid  out  1  code available
- out_ready  in  1  consumer takes the code
- code  out  MAX_BITS  code bits, first bin at the MSB of the used field, right-aligned
- code_len  out  LEN_BITS  number of valid bits in `code`
- overflow  out  1  code exceeded MAX_BITS (see Configuration)

## Operation
- States: IDLE, PREFIX, SUFFIX, SIGN, OUT. All state advances happen on the rising edge of `clk`.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready` the block latches k, mode and the mapped value v, clears the shift register and `code_len`, and moves to PREFIX.
- Value mapping (v is VAL_BITS wide):
  - mode 00: v = zero-extended `symbol_val`.
  - mode 01: v = |`symbol_val|`; -2^(SYMBOL_BITS-1) maps to 2^(SYMBOL_BITS-1). The sign is latched.
  - mode 10: v = 2s-1 for s>0, and v = -2s for s≤0.
- PREFIX, one bin per cycle:
  - If v ≥ 2^k: shift in 1, v ← v - 2^k, k ← k+1. k saturates at SYMBOL_BITS.
  - Otherwise: shift in 0. Then go to SUFFIX if k>0, else go to SIGN/OUT.
- SUFFIX: shift in bits v[k-1] down to v[0], one per cycle, MSB first, using a counter. After the last bit, go to SIGN/OUT.
- SIGN: entered only when mode=01 and the original symbol is non-zero. Shift in the sign bit (1 = negative), then go to OUT.
- Every shifted bin does code ← (code<<1)|bin and code_len ← code_len+1.
- OUT: `out_valid`=1; `code`, `code_len` and `overflow` stay stable. On `out_ready` the block goes to IDLE.
- `in_ready` is 1 only in IDLE. There is no overlap between symbols.

## Timing
- Reset values: `in_ready`=0 while `rst_n` is low, then 1 in IDLE. `out_valid`=0, `code`=0, `code_len`=0, `overflow`=0, state=IDLE.
- Asserting `rst_n` low mid-encode aborts immediately to the reset values. No partial code is ever presented.
- Latency: `out_valid` rises exactly N rising edges after the accept edge, where N is the final `code_len`. The throughput is one symbol per N+2 cycles (N bin cycles, the handshake cycle in OUT, then one cycle in IDLE).
- `out_valid` is held, with `code`, `code_len` and `overflow` unchanged, for as long as `out_ready` is low.
- `out_ready` while not in OUT is ignored. `in_valid` while not in IDLE is ignored.

## Configuration
- `EGK_OVERFLOW_CHECK_EN` defined:
  - If a bin would make code_len exceed MAX_BITS, the FSM drops that bin and jumps straight to OUT.
  - It then sets `overflow`=1 and `code_len`=MAX_BITS; `code` holds the first MAX_BITS bins.
  - `overflow` clears on the next accept.
- Not defined:
  - `overflow` is tied to 0 and no length check is made.
  - On a long code the shift register keeps the last MAX_BITS bins and `code_len` wraps modulo 2^LEN_BITS.

## Test plan
- K=0, mode 00, value 0 → code=0, code_len=1, `out_valid` 1 edge after accept.
- K=0, mode 00, value 3 → bins 11000, code=5'b11000, code_len=5. Repeat with K=1, value 5 → code=4'b1011, code_len=4.
- K=0, mode 10, value 8'hFE (−2, mapped to 4) → code=5'b11001, code_len=5. Mode 01, value 8'hFF (−1) → code=4'b1001, code_len=4. Mode 01, value 0 → code=0, code_len=1, with no sign bin.
- MAX_BITS=16, K=0, mode 00, value 255 → with `EGK_OVERFLOW_CHECK_EN`: code=16'hFF00, code_len=16, overflow=1. Without it: overflow=0.
- Backpressure: hold `out_ready`=0 for 10 cycles → outputs stable and `in_ready`=0 throughout. Raise `out_ready` → IDLE next cycle and a back-to-back symbol is accepted.
- Pull `rst_n` low during PREFIX of value 200 → all outputs at reset values. The next symbol then encodes correctly.
